// File: rtl/max30102_pkg.sv
// Shared types and constants for the MAX30102 sensor driver.
// Used by the bus scheduler and its arbiter.
package max30102_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_FIN     = 3'd4,
        ST_RECOVER = 3'd5
    } sched_state_t;

    localparam logic [1:0] REQ_CFG  = 2'd0;
    localparam logic [1:0] REQ_FIFO = 2'd1;
    localparam logic [1:0] REQ_TEMP = 2'd2;

    localparam logic [7:0] FIFO_DATA   = 8'h07;
    localparam logic [7:0] TEMP_INT    = 8'h1F;
    localparam logic [7:0] TEMP_CONFIG = 8'h21;

    // A zero read length still moves one byte on the wire.
    function automatic logic [4:0] eff_len(input logic [4:0] len);
        return (len == 5'd0) ? 5'd1 : len;
    endfunction

endpackage

// File: rtl/prio_arb_starve.sv
// Fixed-priority arbiter (index 0 highest) with a starvation
// override that forces the temperature poller after a run of losses.
module prio_arb_starve
    import max30102_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] req,
    input  logic       upd,
    output logic [1:0] win_idx,
    output logic       win_any
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          force_temp;

    always_comb begin
        win_any    = |req;
        force_temp = req[2] && (starve_cnt >= LIM);
        win_idx    = REQ_TEMP;
        unique case (1'b1)
            force_temp:                      win_idx = REQ_TEMP;
            !force_temp && req[0]:           win_idx = REQ_CFG;
            !force_temp && !req[0] && req[1]: win_idx = REQ_FIFO;
            default:                         win_idx = REQ_TEMP;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            starve_cnt <= '0;
        end else if (upd && win_any) begin
            if (win_idx == REQ_TEMP || !req[2])
                starve_cnt <= '0;
            else if (starve_cnt != LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/max30102_bus_sched.sv
// Single-owner scheduler for the shared MAX30102 I2C master:
// arbitrates, issues one burst at a time, routes read bytes, recovers.
module max30102_bus_sched
    import max30102_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 5_000_000,
    parameter int RECOVER_CYC  = 500
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_reg,
    input  logic [8*NREQ-1:0] req_wdata,
    input  logic [5*NREQ-1:0] req_len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [1:0]        rd_owner,
    output logic              m_start,
    output logic              m_wr,
    output logic [7:0]        m_reg,
    output logic [7:0]        m_wdata,
    output logic [4:0]        m_len,
    input  logic              m_byte_valid,
    input  logic [7:0]        m_rdata,
    input  logic              m_done,
    input  logic              m_nack,
    output logic              m_recover
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RECOVER_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RECOVER_CYC - 1);

    sched_state_t  state;
    logic [1:0]    owner;
    logic [4:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;

    logic [1:0]    win_idx;
    logic          win_any;
    logic          accept;
    logic [4:0]    bytes_now;
    logic          txn_ok;

    prio_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .upd       (state == ST_ARB),
        .win_idx   (win_idx),
        .win_any   (win_any)
    );

    // Bytes past the requested length are swallowed, not forwarded.
    always_comb begin
        accept    = m_byte_valid && (bcnt < m_len);
        bytes_now = bcnt + {4'd0, accept};
        txn_ok    = !m_nack && (m_wr || bytes_now == m_len);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
            rcnt      <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_owner  <= '0;
            m_start   <= 1'b0;
            m_wr      <= 1'b0;
            m_reg     <= '0;
            m_wdata   <= '0;
            m_len     <= '0;
            m_recover <= 1'b0;
        end else begin
            m_start  <= 1'b0;
            done     <= '0;
            err      <= '0;
            rd_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|req)
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (win_any) begin
                        owner   <= win_idx;
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        m_wr    <= req_wr[win_idx];
                        m_reg   <= req_reg[8*win_idx +: 8];
                        m_wdata <= req_wdata[8*win_idx +: 8];
                        m_len   <= eff_len(req_len[5*win_idx +: 5]);
                        m_start <= 1'b1;
                        state   <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    bcnt  <= '0;
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (accept) begin
                        rd_data  <= m_rdata;
                        rd_valid <= 1'b1;
                        rd_owner <= owner;
                        bcnt     <= bytes_now;
                    end
                    // Completion beats a timeout landing on the same cycle.
                    if (m_done) begin
                        if (txn_ok)
                            done <= gnt;
                        else
                            err <= gnt;
                        state <= ST_FIN;
                    end else if (tcnt == T_LAST) begin
                        err       <= gnt;
                        gnt       <= '0;
                        m_recover <= 1'b1;
                        rcnt      <= '0;
                        state     <= ST_RECOVER;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
                ST_RECOVER: begin
                    if (rcnt == R_LAST) begin
                        m_recover <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max30102_bus_sched.sv
// Randomized scenario bench for max30102_bus_sched with an
// in-bench engine stub and a rule-level arbitration model.
module tb_max30102_bus_sched;

    localparam int TO = 300;
    localparam int RC = 500;
    localparam int SL = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  req_wr = '0;
    logic [23:0] req_reg = '0;
    logic [23:0] req_wdata = '0;
    logic [14:0] req_len = '0;
    logic [2:0]  gnt, done, err;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [1:0]  rd_owner;
    logic        m_start, m_wr, m_recover;
    logic [7:0]  m_reg, m_wdata;
    logic [4:0]  m_len;
    logic        m_byte_valid = 1'b0;
    logic [7:0]  m_rdata = '0;
    logic        m_done = 1'b0;
    logic        m_nack = 1'b0;

    max30102_bus_sched #(
        .STARVE_LIMIT(SL), .TIMEOUT(TO), .RECOVER_CYC(RC)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req(req), .req_wr(req_wr), .req_reg(req_reg),
        .req_wdata(req_wdata), .req_len(req_len),
        .gnt(gnt), .done(done), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_owner(rd_owner),
        .m_start(m_start), .m_wr(m_wr), .m_reg(m_reg),
        .m_wdata(m_wdata), .m_len(m_len),
        .m_byte_valid(m_byte_valid), .m_rdata(m_rdata),
        .m_done(m_done), .m_nack(m_nack), .m_recover(m_recover)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    int n_start = 0;
    int n_done = 0;
    int n_err = 0;
    logic [7:0] rd_q[$];
    logic [1:0] own_q[$];
    logic [7:0] exp_q[$];

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (m_start) n_start++;
            if (done != 3'b000) n_done++;
            if (err != 3'b000) n_err++;
            if (rd_valid) begin
                rd_q.push_back(rd_data);
                own_q.push_back(rd_owner);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_start(input int budget, output int lat, output bit ok);
        ok = 1'b0;
        lat = budget;
        for (int i = 0; i < budget; i++) begin
            step();
            if (m_start) begin
                ok = 1'b1;
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic set_req(input int r, input bit wr, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [4:0] len);
        req_wr[r] = wr;
        req_reg[8*r +: 8] = rg;
        req_wdata[8*r +: 8] = wd;
        req_len[5*r +: 5] = len;
        req[r] = 1'b1;
    endtask

    task automatic send_bytes(input int n, input int lim);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 2));
            m_byte_valid = 1'b1;
            m_rdata = 8'($urandom);
            if (i < lim) exp_q.push_back(m_rdata);
            step();
            m_byte_valid = 1'b0;
        end
    endtask

    task automatic pulse_done(input bit nack);
        m_done = 1'b1;
        m_nack = nack;
        step();
        m_done = 1'b0;
        m_nack = 1'b0;
    endtask

    // Rule-level winner: temp poller forced after SL losses, else lowest index.
    function automatic int pick(input logic [2:0] p, input int w);
        if (p[2] && w >= SL) return 2;
        for (int i = 0; i < 3; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [43:0] all_out();
        return {gnt, done, err, rd_data, rd_valid, rd_owner, m_start,
                m_wr, m_reg, m_wdata, m_len, m_recover};
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step(2);
        checks++;
        if (all_out() !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out());
        end
        sys_rst_n = 1'b1;
        step(2);
        checks++;
        if (all_out() !== 44'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %h want 0", all_out());
        end
    endtask

    task automatic test_single_read();
        for (int t = 0; t < 3; t++) begin
            int r, lat, base, s0, d0, e0;
            bit ok;
            logic [7:0] rg;
            logic [4:0] len;
            r = (t == 0) ? 1 : int'($urandom_range(0, 2));
            len = (t == 0) ? 5'd6 : 5'($urandom_range(1, 12));
            rg = (t == 0) ? 8'h07 : 8'($urandom);
            exp_q.delete();
            base = rd_q.size();
            s0 = n_start;
            d0 = n_done;
            e0 = n_err;
            set_req(r, 1'b0, rg, 8'h00, len);
            wait_start(8, lat, ok);
            checks++;
            if (!ok || lat != 2) begin
                errors++;
                $display("FAIL rd_latency: got %0d want 2", lat);
            end
            checks++;
            if (gnt !== 3'(1 << r) || m_reg !== rg || m_len !== len || m_wr !== 1'b0) begin
                errors++;
                $display("FAIL rd_cmd: got gnt=%b reg=%h len=%0d wr=%b want gnt=%b reg=%h len=%0d wr=0",
                         gnt, m_reg, m_len, m_wr, 3'(1 << r), rg, len);
            end
            step();
            send_bytes(int'(len), int'(len));
            pulse_done(1'b0);
            checks++;
            if (done !== 3'(1 << r) || err !== 3'b000) begin
                errors++;
                $display("FAIL rd_done: got done=%b err=%b want done=%b err=000",
                         done, err, 3'(1 << r));
            end
            req[r] = 1'b0;
            step(3);
            checks++;
            if (rd_q.size() - base != exp_q.size()) begin
                errors++;
                $display("FAIL rd_count: got %0d want %0d", rd_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < rd_q.size(); i++) begin
                checks++;
                if (rd_q[base+i] !== exp_q[i] || own_q[base+i] !== 2'(r)) begin
                    errors++;
                    $display("FAIL rd_byte%0d: got %h/%0d want %h/%0d",
                             i, rd_q[base+i], own_q[base+i], exp_q[i], r);
                end
            end
            checks++;
            if (n_start - s0 != 1 || n_done - d0 != 1 || n_err != e0) begin
                errors++;
                $display("FAIL rd_pulses: got start=%0d done=%0d err=%0d want 1/1/0",
                         n_start - s0, n_done - d0, n_err - e0);
            end
        end
    endtask

    task automatic test_priority();
        logic [2:0] pend;
        int w;
        pend = 3'b111;
        w = 0;
        req_wr = 3'b111;
        req_len = '0;
        req = 3'b111;
        for (int g = 0; g < 3; g++) begin
            int e, lat;
            bit ok;
            e = pick(pend, w);
            wait_start(12, lat, ok);
            checks++;
            if (!ok || gnt !== 3'(1 << e)) begin
                errors++;
                $display("FAIL prio_grant%0d: got %b want %b", g, gnt, 3'(1 << e));
            end
            w = (e == 2 || !pend[2]) ? 0 : w + 1;
            step();
            pulse_done(1'b0);
            checks++;
            if (done !== 3'(1 << e)) begin
                errors++;
                $display("FAIL prio_done%0d: got %b want %b", g, done, 3'(1 << e));
            end
            req[e] = 1'b0;
            pend[e] = 1'b0;
        end
        step(3);
    endtask

    task automatic test_starve();
        int w, got2;
        w = 0;
        got2 = -1;
        req_wr = 3'b111;
        req = 3'b111;
        for (int g = 1; g <= 12; g++) begin
            int e, lat;
            bit ok;
            e = pick(3'b111, w);
            wait_start(12, lat, ok);
            checks++;
            if (!ok || gnt !== 3'(1 << e)) begin
                errors++;
                $display("FAIL starve_grant%0d: got %b want %b", g, gnt, 3'(1 << e));
            end
            w = (e == 2) ? 0 : w + 1;
            step();
            pulse_done(1'b0);
            if (gnt === 3'b100) got2 = g;
            if (e == 2 || got2 > 0) begin
                req = 3'b000;
                break;
            end
        end
        checks++;
        if (got2 != 9) begin
            errors++;
            $display("FAIL starve_slot: got %0d want 9", got2);
        end
        req = 3'b000;
        step(4);
    endtask

    task automatic test_short_read();
        int lens[4] = '{6, 3, 0, 0};
        int nb[4]   = '{4, 5, 1, 0};
        for (int t = 0; t < 4; t++) begin
            int eff, acc, lat, base;
            bit ok, good;
            eff = (lens[t] == 0) ? 1 : lens[t];
            acc = (nb[t] < eff) ? nb[t] : eff;
            good = (nb[t] >= eff);
            exp_q.delete();
            base = rd_q.size();
            set_req(1, 1'b0, 8'h07, 8'h00, 5'(lens[t]));
            wait_start(8, lat, ok);
            step();
            send_bytes(nb[t], eff);
            pulse_done(1'b0);
            checks++;
            if (done !== (good ? 3'b010 : 3'b000) || err !== (good ? 3'b000 : 3'b010)) begin
                errors++;
                $display("FAIL short_%0d: got done=%b err=%b want ok=%0d", t, done, err, good);
            end
            req[1] = 1'b0;
            step(3);
            checks++;
            if (rd_q.size() - base != acc) begin
                errors++;
                $display("FAIL short_cnt%0d: got %0d want %0d", t, rd_q.size() - base, acc);
            end
            for (int i = 0; i < acc && base + i < rd_q.size(); i++) begin
                checks++;
                if (rd_q[base+i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL short_byte%0d_%0d: got %h want %h", t, i, rd_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_nack();
        int lat;
        bit ok;
        logic [7:0] rg, wd;
        set_req(0, 1'b1, 8'h21, 8'h01, 5'd0);
        wait_start(8, lat, ok);
        checks++;
        if (!ok || m_wr !== 1'b1 || m_reg !== 8'h21 || m_wdata !== 8'h01) begin
            errors++;
            $display("FAIL nack_cmd: got wr=%b reg=%h wd=%h want 1/21/01", m_wr, m_reg, m_wdata);
        end
        step();
        pulse_done(1'b1);
        checks++;
        if (err !== 3'b001 || done !== 3'b000) begin
            errors++;
            $display("FAIL nack_err: got err=%b done=%b want 001/000", err, done);
        end
        req[0] = 1'b0;
        step();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL nack_gnt: got %b want 000", gnt);
        end
        rg = 8'($urandom);
        wd = 8'($urandom);
        set_req(0, 1'b1, rg, wd, 5'd0);
        wait_start(8, lat, ok);
        checks++;
        if (!ok || lat != 2 || m_reg !== rg || m_wdata !== wd) begin
            errors++;
            $display("FAIL wr_cmd: got lat=%0d reg=%h wd=%h want 2/%h/%h", lat, m_reg, m_wdata, rg, wd);
        end
        step($urandom_range(1, 5));
        pulse_done(1'b0);
        checks++;
        if (done !== 3'b001 || err !== 3'b000) begin
            errors++;
            $display("FAIL wr_done: got done=%b err=%b want 001/000", done, err);
        end
        req[0] = 1'b0;
        step(3);
    endtask

    task automatic test_timeout();
        int lat, rc, seen, d0, e0, r0, s0;
        bit ok;
        // m_done on the last allowed WAIT cycle still completes normally.
        set_req(0, 1'b0, 8'h1F, 8'h00, 5'd1);
        wait_start(8, lat, ok);
        step();
        m_byte_valid = 1'b1;
        m_rdata = 8'h5A;
        step();
        m_byte_valid = 1'b0;
        step(TO - 2);
        pulse_done(1'b0);
        checks++;
        if (done !== 3'b001 || err !== 3'b000 || m_recover !== 1'b0) begin
            errors++;
            $display("FAIL to_edge: got done=%b err=%b rec=%b want 001/000/0", done, err, m_recover);
        end
        req[0] = 1'b0;
        step(3);

        set_req(0, 1'b0, 8'h07, 8'h00, 5'd2);
        wait_start(8, lat, ok);
        seen = -1;
        for (int i = 1; i <= TO + 20; i++) begin
            step();
            if (i == 3) set_req(2, 1'b1, 8'h21, 8'h01, 5'd0);
            if (err !== 3'b000) begin
                seen = i;
                break;
            end
        end
        checks++;
        if (seen != TO + 1) begin
            errors++;
            $display("FAIL to_cycle: got %0d want %0d", seen, TO + 1);
        end
        checks++;
        if (err !== 3'b001 || gnt !== 3'b000 || m_recover !== 1'b1) begin
            errors++;
            $display("FAIL to_err: got err=%b gnt=%b rec=%b want 001/000/1", err, gnt, m_recover);
        end
        req[0] = 1'b0;
        d0 = n_done;
        e0 = n_err;
        r0 = rd_q.size();
        s0 = n_start;
        rc = 0;
        for (int i = 0; i < RC + 20; i++) begin
            if (!m_recover) break;
            rc++;
            m_done = (i < 10);
            m_byte_valid = (i < 10);
            step();
        end
        m_done = 1'b0;
        m_byte_valid = 1'b0;
        checks++;
        if (rc != RC) begin
            errors++;
            $display("FAIL rec_len: got %0d want %0d", rc, RC);
        end
        checks++;
        if (n_done != d0 || n_err != e0 || rd_q.size() != r0 || n_start != s0) begin
            errors++;
            $display("FAIL rec_ignore: got done+%0d err+%0d rd+%0d start+%0d want 0",
                     n_done - d0, n_err - e0, rd_q.size() - r0, n_start - s0);
        end
        wait_start(8, lat, ok);
        checks++;
        if (!ok || lat != 2 || gnt !== 3'b100) begin
            errors++;
            $display("FAIL rec_next: got lat=%0d gnt=%b want 2/100", lat, gnt);
        end
        step();
        pulse_done(1'b0);
        checks++;
        if (done !== 3'b100) begin
            errors++;
            $display("FAIL rec_done: got %b want 100", done);
        end
        req[2] = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        set_req(0, 1'b0, 8'h07, 8'h00, 5'd3);
        wait_start(8, lat, ok);
        step(2);
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL mid_pre: got %b want 001", gnt);
        end
        #2;
        sys_rst_n = 1'b0;
        req = 3'b000;
        #1;
        checks++;
        if (all_out() !== 44'd0) begin
            errors++;
            $display("FAIL mid_async: got %h want 0", all_out());
        end
        step(2);
        sys_rst_n = 1'b1;
        step();
        set_req(0, 1'b1, 8'h21, 8'h02, 5'd0);
        wait_start(8, lat, ok);
        checks++;
        if (!ok || lat != 2 || gnt !== 3'b001) begin
            errors++;
            $display("FAIL mid_restart: got lat=%0d gnt=%b want 2/001", lat, gnt);
        end
        step();
        pulse_done(1'b0);
        checks++;
        if (done !== 3'b001) begin
            errors++;
            $display("FAIL mid_done: got %b want 001", done);
        end
        req[0] = 1'b0;
        step(3);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_starve();
        test_short_read();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
